// File: rtl/mips_hilo_unit_pkg.sv
// Shared encodings for the HI/LO unit: source selects, FSM states, engine op.
package mips_hilo_unit_pkg;
  localparam int HI_LO_SEL_WIDTH = 2;

  localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_HOLD = 2'b00;
  localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_RS   = 2'b01;
  localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_DIV  = 2'b10;
  localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_MULT = 2'b11;

  typedef enum logic [1:0] {HILO_IDLE, HILO_BUSY, HILO_DONE} hilo_state_t;
  typedef enum logic {OP_MULT, OP_DIV} muldiv_op_t;
endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned magnitude engine: one shift-add (MULT) or restoring-subtract (DIV)
// step per cycle into a 2*DATA_WIDTH accumulator.
module mips_muldiv_core
  import mips_hilo_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  muldiv_op_t              op,
  input  logic [DATA_WIDTH-1:0]   a_mag,
  input  logic [DATA_WIDTH-1:0]   b_mag,
  output logic [DATA_WIDTH-1:0]   acc_hi,
  output logic [DATA_WIDTH-1:0]   acc_lo,
  output logic                    last_iter
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER_CYCLES - 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  muldiv_op_t     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W:0]     sum, trial;
  logic [2*W:0]   add_shr;
  logic [2*W-1:0] shl;

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    add_shr = {sum, acc_q[W-1:0]};
    shl     = {acc_q[2*W-2:0], 1'b0};
    // Remainder stays below the divisor, so the shifted upper half never loses a bit.
    trial   = {1'b0, shl[2*W-1:W]} - {1'b0, opnd_q};
    if (load) begin
      op_d   = op;
      cnt_d  = '0;
      acc_d  = (op == OP_MULT) ? {{W{1'b0}}, b_mag} : {{W{1'b0}}, a_mag};
      opnd_d = (op == OP_MULT) ? a_mag : b_mag;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q == OP_MULT) begin
        acc_d = acc_q[0] ? add_shr[2*W:1] : {1'b0, acc_q[2*W-1:1]};
      end else begin
        acc_d = trial[W] ? shl : {trial[W-1:0], shl[W-1:1], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= OP_MULT;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc_hi    = acc_q[2*W-1:W];
  assign acc_lo    = acc_q[W-1:0];
  assign last_iter = (cnt_q == LAST);
endmodule

// File: rtl/mips_hilo_unit.sv
// HI/LO registers with MTHI/MTLO writes and a multi-cycle signed MULT/DIV;
// holds stall high while the engine runs.
module mips_hilo_unit
  import mips_hilo_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hi_write,
  input  logic                       lo_write,
  input  logic [HI_LO_SEL_WIDTH-1:0] hi_select,
  input  logic [HI_LO_SEL_WIDTH-1:0] lo_select,
  input  logic [DATA_WIDTH-1:0]      rs_data,
  input  logic [DATA_WIDTH-1:0]      rt_data,
  output logic [DATA_WIDTH-1:0]      hi_out,
  output logic [DATA_WIDTH-1:0]      lo_out,
  output logic                       stall,
  output logic                       busy
);
  localparam int W = DATA_WIDTH;

  hilo_state_t   state_q, state_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, rs_raw_q, rs_raw_d;
  logic          sign_rs_q, sign_rs_d, sign_rt_q, sign_rt_d, rt_zero_q, rt_zero_d;
  muldiv_op_t    op_q, op_d, start_op;

  logic          start, core_load, core_step, last_iter;
  logic [W-1:0]  rs_mag, rt_mag, acc_hi, acc_lo, quo, rem;
  logic [2*W-1:0] prod;

  assign rs_mag   = rs_data[W-1] ? (~rs_data + 1'b1) : rs_data;
  assign rt_mag   = rt_data[W-1] ? (~rt_data + 1'b1) : rt_data;
  assign start    = hi_write && lo_write && (hi_select == lo_select) &&
                    ((hi_select == HILO_SEL_DIV) || (hi_select == HILO_SEL_MULT));
  assign start_op = (hi_select == HILO_SEL_DIV) ? OP_DIV : OP_MULT;

  mips_muldiv_core #(.DATA_WIDTH(DATA_WIDTH), .ITER_CYCLES(ITER_CYCLES)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load),
    .step      (core_step),
    .op        (start_op),
    .a_mag     (rs_mag),
    .b_mag     (rt_mag),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .last_iter (last_iter)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rs_raw_d  = rs_raw_q;
    sign_rs_d = sign_rs_q;
    sign_rt_d = sign_rt_q;
    rt_zero_d = rt_zero_q;
    op_d      = op_q;
    core_load = 1'b0;
    core_step = 1'b0;
    stall     = 1'b0;
    prod      = (sign_rs_q ^ sign_rt_q) ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    quo       = (sign_rs_q ^ sign_rt_q) ? (~acc_lo + 1'b1) : acc_lo;
    rem       = sign_rs_q ? (~acc_hi + 1'b1) : acc_hi;
    unique case (state_q)
      HILO_IDLE: begin
        if (start) begin
          state_d   = HILO_BUSY;
          core_load = 1'b1;
          stall     = 1'b1;
          op_d      = start_op;
          rs_raw_d  = rs_data;
          sign_rs_d = rs_data[W-1];
          sign_rt_d = rt_data[W-1];
          rt_zero_d = (rt_data == '0);
        end else begin
          if (hi_write && hi_select == HILO_SEL_RS) hi_d = rs_data;
          if (lo_write && lo_select == HILO_SEL_RS) lo_d = rs_data;
        end
      end
      HILO_BUSY: begin
        core_step = 1'b1;
        stall     = 1'b1;
        if (last_iter) state_d = HILO_DONE;
      end
      HILO_DONE: begin
        state_d = HILO_IDLE;
        if (op_q == OP_MULT) begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end else if (rt_zero_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = HILO_IDLE;
    endcase
    // Reset aborts everything, including the stall request of this cycle.
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HILO_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_raw_q  <= '0;
      sign_rs_q <= 1'b0;
      sign_rt_q <= 1'b0;
      rt_zero_q <= 1'b0;
      op_q      <= OP_MULT;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rs_raw_q  <= rs_raw_d;
      sign_rs_q <= sign_rs_d;
      sign_rt_q <= sign_rt_d;
      rt_zero_q <= rt_zero_d;
      op_q      <= op_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q == HILO_BUSY);
endmodule
